// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding, ALU operand select and load-use detection
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int AOP_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [DW-1:0]    id_rs_data,
    input  logic [DW-1:0]    id_rt_data,
    input  logic [RW-1:0]    id_rs_addr,
    input  logic [RW-1:0]    id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [15:0]      id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [AOP_W-1:0] id_aluop,
    input  logic [1:0]       id_alusrc,
    input  logic             id_shift,
    input  logic [RW-1:0]    id_wsel,
    input  logic             id_regwen,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             exmem_regwen,
    input  logic [RW-1:0]    exmem_wsel,
    input  logic [DW-1:0]    exmem_data,
    input  logic             memwb_regwen,
    input  logic [RW-1:0]    memwb_wsel,
    input  logic [DW-1:0]    memwb_data,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_portA,
    output logic [DW-1:0]    ex_portB,
    output logic [AOP_W-1:0] ex_aluop,
    output logic [DW-1:0]    ex_store_data,
    output logic [RW-1:0]    ex_wsel,
    output logic             ex_regwen,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             load_use_stall
);
    logic             valid;
    logic [DW-1:0]    rs_data;
    logic [DW-1:0]    rt_data;
    logic [RW-1:0]    rs_addr;
    logic [RW-1:0]    rt_addr;
    logic [15:0]      imm;
    logic [4:0]       shamt;
    logic [AOP_W-1:0] aluop;
    logic [1:0]       alusrc;
    logic             shift;
    logic [RW-1:0]    wsel;
    logic             regwen;
    logic             memread;
    logic             memwrite;
    logic [DW-1:0]    fwd_rs;
    logic [DW-1:0]    fwd_rt;

    // pipeline register: reset clears, flush bubbles even while held, en advances
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid    <= 1'b0;
            rs_data  <= '0;
            rt_data  <= '0;
            rs_addr  <= '0;
            rt_addr  <= '0;
            imm      <= '0;
            shamt    <= '0;
            aluop    <= '0;
            alusrc   <= '0;
            shift    <= 1'b0;
            wsel     <= '0;
            regwen   <= 1'b0;
            memread  <= 1'b0;
            memwrite <= 1'b0;
        end else if (flush) begin
            valid    <= 1'b0;
            regwen   <= 1'b0;
            memread  <= 1'b0;
            memwrite <= 1'b0;
        end else if (en) begin
            valid    <= id_valid;
            rs_data  <= id_rs_data;
            rt_data  <= id_rt_data;
            rs_addr  <= id_rs_addr;
            rt_addr  <= id_rt_addr;
            imm      <= id_imm;
            shamt    <= id_shamt;
            aluop    <= id_aluop;
            alusrc   <= id_alusrc;
            shift    <= id_shift;
            wsel     <= id_wsel;
            regwen   <= id_regwen;
            memread  <= id_memread;
            memwrite <= id_memwrite;
        end
    end

    // forwarding, EX/MEM before MEM/WB, re-evaluated every cycle so held instructions see advancing producers
    always_comb begin
        fwd_rs = (exmem_regwen && exmem_wsel != '0 && exmem_wsel == rs_addr) ? exmem_data :
                 (memwb_regwen && memwb_wsel != '0 && memwb_wsel == rs_addr) ? memwb_data : rs_data;
        fwd_rt = (exmem_regwen && exmem_wsel != '0 && exmem_wsel == rt_addr) ? exmem_data :
                 (memwb_regwen && memwb_wsel != '0 && memwb_wsel == rt_addr) ? memwb_data : rt_data;
    end

    // ALU operands, gated control and load-use request
    always_comb begin
        ex_valid       = valid;
        ex_aluop       = aluop;
        ex_wsel        = wsel;
        ex_regwen      = regwen & valid;
        ex_memread     = memread & valid;
        ex_memwrite    = memwrite & valid;
        ex_store_data  = fwd_rt;
        ex_portA       = shift ? {{(DW-5){1'b0}}, shamt} : fwd_rs;
        ex_portB       = (alusrc == 2'b00) ? fwd_rt :
                         (alusrc == 2'b01) ? {{(DW-16){imm[15]}}, imm} :
                         (alusrc == 2'b10) ? {{(DW-16){1'b0}}, imm} : {imm, {(DW-16){1'b0}}};
        load_use_stall = valid & memread & (wsel != '0) &
                         ((id_valid & id_uses_rs & (id_rs_addr == wsel)) |
                          (id_valid & id_uses_rt & (id_rt_addr == wsel)));
    end
endmodule
